gpio_port_irq: RTL
==================

Name: gpio_port_irq

Overview:
- Parametrised general-purpose I/O port peripheral for the J1 IO bus; next generation of the fixed 16-bit porta_in/porta_out/porta_dir registers.
- Adds atomic set/clear/toggle writes, a configurable input synchroniser, and per-bit rising/falling edge detection.
- Edge events latch into a write-1-to-clear pending register that drives one interrupt line.
- Sits beside the CPU in top; SB_IO primitives stay in top and connect to pad_out/pad_oe/pad_in.

Parameters:
- WIDTH, 16, number of port bits (1..16); register bits above WIDTH read 0.
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clk  input  1  system clock (24 MHz domain).
- reset  input  1  synchronous, active-high reset.
- cs  input  1  block select, decoded from one io_addr bit in top.
- regsel  input  4  register index.
- io_wr  input  1  write strobe, single cycle.
- io_rd  input  1  read strobe; has no side effects.
- io_dout  input  16  write data from CPU.
- io_din  output  16  read data; combinational; 0 when cs=0 so it can be OR-merged in top.
- pad_in  input  WIDTH  raw pin levels (asynchronous).
- pad_out  output  WIDTH  output register.
- pad_oe  output  WIDTH  direction register, 1 = drive.
- irq  output  1  registered, OR of pending & enable.

Behaviour:
- Register map, selected by regsel:
  - 0 IN: read only; synchronised input.
  - 1 OUT: read/write.
  - 2 DIR: read/write.
  - 3 SET: write does OUT |= d.
  - 4 CLR: write does OUT &= ~d.
  - 5 TGL: write does OUT ^= d.
  - 6 RISE_EN: read/write.
  - 7 FALL_EN: read/write.
  - 8 PENDING: read; write-1-to-clear.
  - 9..15: read 0, writes ignored.
  - Reads of 3/4/5 return OUT.
- A write takes effect when io_wr & cs is high at the clk edge, and is visible on the next cycle. Only io_dout[WIDTH-1:0] is used.
- Reset values: OUT=0, DIR=0 (all inputs), RISE_EN=0, FALL_EN=0, PENDING=0, sync chain=0, prev=0, irq=0. pad_out=0 and pad_oe=0 during reset and after it.
- Synchroniser: pad_in passes through SYNC_STAGES flops. IN = last stage. A pin change is visible in IN SYNC_STAGES cycles later.
- Edge detection: prev <= IN every cycle.
  - rise = IN & ~prev & RISE_EN.
  - fall = ~IN & prev & FALL_EN.
  - Detection covers pins in either direction, so output loopback also generates edges.
- Warm-up: a counter of width clog2(SYNC_STAGES+2) loads 0 on reset. It counts to SYNC_STAGES+1 and saturates. Edge detection is suppressed until saturation, so pins high at reset do not raise a spurious rising event.
- PENDING next = (PENDING & ~(W1C mask)) | rise | fall. If an edge and a W1C hit the same bit in the same cycle, the set wins.
- irq <= |(PENDING & (RISE_EN | FALL_EN)), one cycle after PENDING updates.
  - Total latency from a pin edge to irq: SYNC_STAGES+2 cycles.
  - Clearing the enables masks irq without clearing PENDING.
- Writing OUT/SET/CLR/TGL does not touch DIR, and the reverse also holds.
- Reset asserted mid-operation: all state returns to reset values on the next edge and the warm-up restarts.

Decomposition:
- Shared package/include gpio_defs: regsel constants (GPIO_IN..GPIO_PENDING) and the register count.
- One sub-module, sync_edge_detect (WIDTH, SYNC_STAGES): synchroniser, prev register, warm-up counter; outputs level, rise, fall.
- Register file and read mux stay in gpio_port_irq.

Test Plan:
- Reset with pad_in=16'hFFFF, RISE_EN then set to 16'hFFFF: PENDING stays 0 and irq stays 0 for 20 cycles.
- Write OUT=16'h00F0, SET 16'h0003, CLR 16'h0010, TGL 16'h8001: read OUT gives 16'h80E2. pad_out tracks each write one cycle later, and pad_oe stays 0.
- RISE_EN=16'h0004, pad_in bit2 goes 0->1 at cycle n: IN bit2 is high at n+2, PENDING=16'h0004 at n+3, irq=1 at n+4. Writing PENDING=16'h0004 gives PENDING=0 and then irq=0.
- FALL_EN=16'h0001, a falling edge on bit0 lands in the same cycle as a W1C of bit0: PENDING bit0 remains 1.
- WIDTH=8 instance, write 16'hFFFF to OUT: read gives 16'h00FF. regsel=12 reads 0, and cs=0 gives io_din=0 regardless of regsel.
- Reset asserted while PENDING=16'h0011 and irq=1: the next cycle has PENDING=0, irq=0, OUT=0, DIR=0.

Source files
------------

// File: rtl/gpio_defs.sv
// Shared register map and bus width for the GPIO port peripheral.
package gpio_defs;

  localparam int GPIO_BUS_W    = 16;
  localparam int GPIO_NUM_REGS = 9;

  localparam logic [3:0] GPIO_IN      = 4'd0;
  localparam logic [3:0] GPIO_OUT     = 4'd1;
  localparam logic [3:0] GPIO_DIR     = 4'd2;
  localparam logic [3:0] GPIO_SET     = 4'd3;
  localparam logic [3:0] GPIO_CLR     = 4'd4;
  localparam logic [3:0] GPIO_TGL     = 4'd5;
  localparam logic [3:0] GPIO_RISE_EN = 4'd6;
  localparam logic [3:0] GPIO_FALL_EN = 4'd7;
  localparam logic [3:0] GPIO_PENDING = 4'd8;

endpackage

// File: rtl/sync_edge_detect.sv
// Pin synchroniser with per-bit edge detection, held off during warm-up
// so pins already high at reset do not look like rising edges.
module sync_edge_detect #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int                CNT_W     = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  WARM_DONE = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] warm_q;
  logic [CNT_W-1:0] warm_d;
  logic             warm_done;

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // pre-edge value; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      warm_q <= warm_d;
    end
  end

  assign warm_done = (warm_q == WARM_DONE);
  assign warm_d    = warm_done ? warm_q : warm_q + CNT_W'(1);

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = warm_done ? (level & ~prev_q) : '0;
  assign fall  = warm_done ? (~level & prev_q) : '0;

endmodule

// File: rtl/gpio_port_irq.sv
// GPIO port for the J1 IO bus: OUT/DIR registers with atomic set/clear/toggle,
// synchronised inputs, edge-triggered W1C pending bits and one interrupt line.
module gpio_port_irq
  import gpio_defs::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic [3:0]            regsel,
  input  logic                  io_wr,
  input  logic                  io_rd,
  input  logic [GPIO_BUS_W-1:0] io_dout,
  output logic [GPIO_BUS_W-1:0] io_din,
  input  logic [WIDTH-1:0]      pad_in,
  output logic [WIDTH-1:0]      pad_out,
  output logic [WIDTH-1:0]      pad_oe,
  output logic                  irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] in_level, in_rise, in_fall;
  logic [WIDTH-1:0] wdata, w1c_mask, rdata;
  logic             wr_en;

  // Reads are side-effect free and upper data bits are ignored for narrow ports.
  logic unused_bus;
  assign unused_bus = ^{io_rd, io_dout};

  sync_edge_detect #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pad_in (pad_in),
    .level  (in_level),
    .rise   (in_rise),
    .fall   (in_fall)
  );

  assign wr_en = io_wr & cs;
  assign wdata = io_dout[WIDTH-1:0];

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_mask  = '0;
    if (wr_en) begin
      case (regsel)
        GPIO_OUT:     out_d     = wdata;
        GPIO_DIR:     dir_d     = wdata;
        GPIO_SET:     out_d     = out_q | wdata;
        GPIO_CLR:     out_d     = out_q & ~wdata;
        GPIO_TGL:     out_d     = out_q ^ wdata;
        GPIO_RISE_EN: rise_en_d = wdata;
        GPIO_FALL_EN: fall_en_d = wdata;
        GPIO_PENDING: w1c_mask  = wdata;
        default:      ;
      endcase
    end
    // A new edge in the same cycle as its W1C keeps the bit set.
    pend_d = (pend_q & ~w1c_mask) | (in_rise & rise_en_q) | (in_fall & fall_en_q);
    irq_d  = |(pend_q & (rise_en_q | fall_en_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (regsel)
      GPIO_IN:      rdata = in_level;
      GPIO_OUT,
      GPIO_SET,
      GPIO_CLR,
      GPIO_TGL:     rdata = out_q;
      GPIO_DIR:     rdata = dir_q;
      GPIO_RISE_EN: rdata = rise_en_q;
      GPIO_FALL_EN: rdata = fall_en_q;
      GPIO_PENDING: rdata = pend_q;
      default:      rdata = '0;
    endcase
    // Zero when deselected so top can OR this with other peripherals.
    io_din = '0;
    if (cs) io_din[WIDTH-1:0] = rdata;
  end

  assign pad_out = out_q;
  assign pad_oe  = dir_q;
  assign irq     = irq_q;

endmodule
